// File: rtl/neurocore_serial_hub_if.sv
// Core-side byte handshake and status bundle of the neurocore serial hub.
// The hub drives the slave side; the neural core drives the master side.
interface neurocore_serial_hub_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [CNT_W-1:0]     rx_count;
  logic                 rx_overrun;
  logic                 frame_err;
  logic                 tx_busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, rx_count, rx_overrun, frame_err, tx_busy,
    output rx_ready, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, rx_count, rx_overrun, frame_err, tx_busy,
    input  rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/neurocore_serial_hub.sv
// UART receiver with RX FIFO, single-buffer UART transmitter and hardware echo mode
// for the neurocore tile; the core side is a pair of valid/ready byte streams.
module neurocore_serial_hub #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  RXD,
  output logic                  TXD,
  input  logic                  loopback,
  neurocore_serial_hub_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [OW-1:0] FULL     = OW'(FIFO_DEPTH);

  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

  state_e               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_brk_q, rx_brk_d;
  logic                 rx_push, rx_ferr;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] head_q, head_d;
  logic                 fifo_pop, push_ok, overrun;

  state_e               tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 txd_q, txd_d;
  logic                 tx_load;
  logic [DATA_BITS-1:0] tx_byte;

  logic tx_busy_q, frame_err_q, rx_overrun_q;

  // State register for both FSMs, the FIFO bookkeeping and the registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rxd_prev_q   <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_brk_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      txd_q        <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rxd_meta_q   <= RXD;
      rxd_sync_q   <= rxd_meta_q;
      rxd_prev_q   <= rxd_sync_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_brk_q     <= rx_brk_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      txd_q        <= txd_d;
      tx_busy_q    <= (tx_state_d != S_IDLE);
      frame_err_q  <= rx_ferr;
      rx_overrun_q <= overrun;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && push_ok) begin
      mem_q[wr_ptr_q] <= rx_shift_q;
    end
  end

  // RX next state; a bad stop bit parks in STOP until the line idles so a break cannot retrigger.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_brk_d   = rx_brk_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = CW'(1);
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_BIT) begin
          rx_cnt_d   = CW'(1);
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = CW'(1);
          rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == LAST_BIT) begin
            rx_state_d = S_STOP;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_brk_q) begin
          if (rxd_sync_q) begin
            rx_state_d = S_IDLE;
            rx_brk_d   = 1'b0;
          end
        end else if (rx_cnt_q == BIT_END) begin
          if (rxd_sync_q) begin
            rx_push    = 1'b1;
            rx_state_d = S_IDLE;
          end else begin
            rx_ferr  = 1'b1;
            rx_brk_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // FIFO: in echo mode the head is drained straight into an idle transmitter.
  always_comb begin
    logic [PW-1:0] rd_next;
    fifo_pop = (count_q != '0) && (loopback ? (tx_state_q == S_IDLE) : bus.rx_ready);
    push_ok  = rx_push && ((count_q != FULL) || fifo_pop);
    overrun  = rx_push && (count_q == FULL) && !fifo_pop;
    rd_next  = fifo_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_ptr_d = rd_next;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q + OW'(push_ok) - OW'(fifo_pop);
    // A push landing on the new head slot bypasses the array read.
    head_d   = (push_ok && (wr_ptr_q == rd_next)) ? rx_shift_q : mem_q[rd_next];
  end

  assign tx_load = (tx_state_q == S_IDLE) && (loopback ? (count_q != '0) : bus.tx_valid);
  assign tx_byte = loopback ? head_q : bus.tx_data;

  // TX next state; TXD is registered, so each bit value is set on the edge that starts it.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_load) begin
          tx_state_d = S_START;
          tx_cnt_d   = CW'(1);
          tx_shift_d = tx_byte;
          txd_d      = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = CW'(1);
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = CW'(1);
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rx_valid = (count_q != '0) && !loopback;
    bus.tx_ready = (tx_state_q == S_IDLE) && !loopback;
  end

  assign TXD            = txd_q;
  assign bus.rx_data    = head_q;
  assign bus.rx_count   = count_q;
  assign bus.rx_overrun = rx_overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.tx_busy    = tx_busy_q;
endmodule

// File: tb/tb_neurocore_serial_hub.sv
// Directed bench for neurocore_serial_hub: RX/TX frame tables plus hand-written
// sequences for overrun, framing errors, glitches, echo mode and mid-frame reset.
module tb_neurocore_serial_hub;
  localparam int CPB   = 8;
  localparam int DB    = 8;
  localparam int DEPTH = 4;

  logic CLK      = 1'b0;
  logic RESET    = 1'b0;
  logic RXD      = 1'b1;
  logic loopback = 1'b0;
  logic TXD;

  neurocore_serial_hub_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus ();

  neurocore_serial_hub #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .RXD     (RXD),
    .TXD     (TXD),
    .loopback(loopback),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    int         exp_ovr;
  } rx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] pattern;  // bit 0 = start bit, bit 9 = stop bit
  } tx_vec_t;

  rx_vec_t rx_tab [5];
  tx_vec_t tx_tab [3];

  int tests = 0;
  int fails = 0;
  int ferr_seen, ovr_seen, valid_hi, valid_at;
  logic [7:0] lb0, lb1;
  logic       ok0, ok1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (bus.frame_err)  ferr_seen++;
    if (bus.rx_overrun) ovr_seen++;
    if (bus.rx_valid)   valid_hi++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr       = {stop, d, 1'b0};
    valid_at = -1;
    for (int i = 0; i < 10 * CPB; i++) begin
      RXD = fr[i / CPB];
      tick();
      if (bus.rx_valid && valid_at < 0) valid_at = i + 1;
    end
    RXD = 1'b1;
  endtask

  task automatic capture_tx(output logic [7:0] b, output logic ok);
    int waited;
    waited = 0;
    b      = '0;
    ok     = 1'b0;
    while (TXD !== 1'b0 && waited < 400) begin
      cyc(1);
      waited++;
    end
    if (TXD === 1'b0) begin
      cyc(CPB / 2);
      ok = (TXD === 1'b0);
      for (int k = 0; k < DB; k++) begin
        cyc(CPB);
        b[k] = TXD;
      end
      cyc(CPB);
      ok = ok && (TXD === 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, unstable;
    logic [9:0] obs;

    rx_tab[0] = '{8'h01, 1, 0};
    rx_tab[1] = '{8'h02, 2, 0};
    rx_tab[2] = '{8'h03, 3, 0};
    rx_tab[3] = '{8'h04, 4, 0};
    rx_tab[4] = '{8'h05, 4, 1};
    tx_tab[0] = '{8'h3C, 10'b1001111000};
    tx_tab[1] = '{8'h81, 10'b1100000010};
    tx_tab[2] = '{8'hA5, 10'b1101001010};

    bus.rx_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    ferr_seen = 0; ovr_seen = 0; valid_hi = 0; valid_at = -1;

    // Reset state
    repeat (3) tick();
    check("rst_txd",       TXD, 1);
    check("rst_rx_valid",  bus.rx_valid, 0);
    check("rst_rx_count",  bus.rx_count, 0);
    check("rst_rx_data",   bus.rx_data, 0);
    check("rst_tx_busy",   bus.tx_busy, 0);
    check("rst_tx_ready",  bus.tx_ready, 1);
    check("rst_pulses",    {30'd0, bus.frame_err, bus.rx_overrun}, 0);

    RESET = 1'b1;
    ferr_seen = 0; ovr_seen = 0; valid_hi = 0;
    repeat (100) tick();
    check("idle_pulses",   ferr_seen + ovr_seen, 0);
    check("idle_rx_valid", valid_hi, 0);
    check("idle_txd",      TXD, 1);
    check("idle_rx_count", bus.rx_count, 0);
    check("idle_tx_ready", bus.tx_ready, 1);

    // Single frame receive and pop
    rx_frame(8'hA5, 1'b1);
    check("rx_first_latency", valid_at, 79);
    check("rx_valid_a5",      bus.rx_valid, 1);
    check("rx_data_a5",       bus.rx_data, 8'hA5);
    check("rx_count_a5",      bus.rx_count, 1);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    check("rx_count_popped",  bus.rx_count, 0);
    check("rx_valid_popped",  bus.rx_valid, 0);

    // Transmit table; a second request mid-frame must be ignored
    for (int v = 0; v < 3; v++) begin
      bus.tx_data  = tx_tab[v].data;
      bus.tx_valid = 1'b1;
      check("tx_ready_before", bus.tx_ready, 1);
      tick();
      bus.tx_valid = 1'b0;
      lows = 0; unstable = 0; obs = '0;
      for (int n = 0; n < 10 * CPB + 5; n++) begin
        if (n == 0) check("tx_busy_start", bus.tx_busy, 1);
        if (n >= 20 && n < 30) begin
          bus.tx_valid = 1'b1;
          bus.tx_data  = ~tx_tab[v].data;
        end else begin
          bus.tx_valid = 1'b0;
        end
        if (!bus.tx_ready) lows++;
        if (n < 10 * CPB) begin
          if (n % CPB == 0) obs[n / CPB] = TXD;
          else if (TXD !== obs[n / CPB]) unstable++;
        end else if (TXD !== 1'b1) begin
          unstable++;
        end
        tick();
      end
      check("tx_pattern",    obs, tx_tab[v].pattern);
      check("tx_unstable",   unstable, 0);
      check("tx_ready_lows", lows, 80);
      check("tx_busy_end",   bus.tx_busy, 0);
    end

    // Five back-to-back frames into a 4-deep FIFO
    for (int v = 0; v < 5; v++) begin
      ovr_seen = 0;
      rx_frame(rx_tab[v].data, 1'b1);
      check("b2b_count",   bus.rx_count, rx_tab[v].exp_count);
      check("b2b_overrun", ovr_seen, rx_tab[v].exp_ovr);
    end
    for (int k = 0; k < 4; k++) begin
      check("pop_valid", bus.rx_valid, 1);
      check("pop_data",  bus.rx_data, rx_tab[k].data);
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
      check("pop_count", bus.rx_count, 3 - k);
    end

    // Bad stop bit, then a short low glitch
    ferr_seen = 0; ovr_seen = 0;
    rx_frame(8'h33, 1'b0);
    check("ferr_pulse",      ferr_seen, 1);
    check("ferr_no_push",    bus.rx_count, 0);
    repeat (6) tick();
    ferr_seen = 0; valid_hi = 0;
    RXD = 1'b0;
    repeat (3) tick();
    RXD = 1'b1;
    repeat (20) tick();
    check("glitch_no_ferr",  ferr_seen, 0);
    check("glitch_no_valid", valid_hi, 0);
    check("glitch_count",    bus.rx_count, 0);
    rx_frame(8'h42, 1'b1);
    check("after_glitch_count", bus.rx_count, 1);
    check("after_glitch_data",  bus.rx_data, 8'h42);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;

    // Echo mode: received bytes reappear on TXD, core handshakes are ignored
    loopback     = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hEE;
    tick();
    check("lb_tx_ready", bus.tx_ready, 0);
    valid_hi = 0;
    fork
      begin
        rx_frame(8'h5A, 1'b1);
        rx_frame(8'hC3, 1'b1);
        repeat (100) tick();
      end
      begin
        capture_tx(lb0, ok0);
        capture_tx(lb1, ok1);
      end
    join
    check("lb_byte0",    lb0, 8'h5A);
    check("lb_frame0",   ok0, 1);
    check("lb_byte1",    lb1, 8'hC3);
    check("lb_frame1",   ok1, 1);
    check("lb_rx_valid", valid_hi, 0);
    check("lb_drained",  bus.rx_count, 0);
    check("lb_txd_idle", TXD, 1);
    bus.tx_valid = 1'b0;
    tick();
    loopback = 1'b0;
    tick();

    // Reset in the middle of a transmit frame with a byte waiting in the FIFO
    rx_frame(8'h77, 1'b1);
    check("mr_count_pre", bus.rx_count, 1);
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    repeat (30) tick();
    check("mr_txd_pre", TXD, 0);
    RESET = 1'b0;
    tick();
    check("mr_txd",      TXD, 1);
    check("mr_count",    bus.rx_count, 0);
    check("mr_rx_valid", bus.rx_valid, 0);
    check("mr_tx_busy",  bus.tx_busy, 0);
    check("mr_tx_ready", bus.tx_ready, 1);
    RESET = 1'b1;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/neurocore_serial_hub.md
Name: neurocore_serial_hub

Overview:
- Parametrised serial front end for the neurocore tile. Replaces the bare RXD/TXD hookup with a configurable UART receiver, an RX FIFO, a single-buffer UART transmitter and a hardware echo (loopback) mode.
- Sits between the tile pins and the neural core. The core exchanges bytes with it through valid/ready handshakes.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit; must be ≥ 4.
- DATA_BITS, 8, payload bits per frame; range 5 to 9; LSB first.
- FIFO_DEPTH, 4, RX FIFO entries; must be a power of two, ≥ 2.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-low reset.
- RXD  input  1  asynchronous serial input; idle high.
- TXD  output  1  serial output; idle high.
- loopback  input  1  1 = echo received frames back out on TXD.
- rx_data  output  DATA_BITS  RX FIFO head entry.
- rx_valid  output  1  RX FIFO non-empty and loopback=0.
- rx_ready  input  1  core pops the head when rx_valid & rx_ready.
- tx_data  input  DATA_BITS  byte to transmit.
- tx_valid  input  1  transmit request.
- tx_ready  output  1  transmitter idle and loopback=0.
- rx_count  output  $clog2(FIFO_DEPTH)+1  current RX FIFO occupancy.
- rx_overrun  output  1  one-cycle pulse: valid frame dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; frame dropped.
- tx_busy  output  1  transmitter not idle.

Behaviour:
- Reset: when RESET=0 at a CLK edge, all state clears.
  - TXD=1; rx_valid=0; rx_count=0; rx_overrun=0; frame_err=0; tx_busy=0.
  - tx_ready=1 once loopback=0.
  - rx_data=0; FIFO pointers=0.
  - Both FSMs go to IDLE.
  - Reset mid-frame aborts the frame; TXD is high on the cycle after the reset edge.
- RXD synchroniser:
  - Two flops; only the synchronised value is used.
  - Latency: 2 cycles.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a synchronised high-to-low transition moves to START. The bit counter loads at that transition.
  - START: samples at CLKS_PER_BIT/2 (integer division). If the sample is high, this is a glitch: return to IDLE with nothing reported. If low, move to DATA.
  - DATA: samples each bit every CLKS_PER_BIT cycles after the start sample. Bits shift in LSB first, DATA_BITS samples in total.
  - STOP: samples one CLKS_PER_BIT after the last data bit.
    - Sample high: push the frame.
    - Sample low: pulse frame_err, drop the frame, and return to IDLE only after RXD is high (a break does not retrigger).
  - Back-to-back frames: the next start edge can be detected the cycle after the stop sample.
- RX FIFO:
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the byte is dropped and rx_overrun pulses on the push cycle. Stored contents are unchanged.
  - Simultaneous push and pop: occupancy is unchanged.
  - rx_data is the registered head entry. It is valid in the cycle rx_valid is high.
  - First-byte latency: rx_valid rises the cycle after the stop sample.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_count is in the range 0..FIFO_DEPTH.
- TX FSM (IDLE, START, DATA, STOP):
  - A byte is accepted on the cycle tx_valid & tx_ready. The byte is latched and tx_busy=1 from the next cycle.
  - Frame sequence, each held exactly CLKS_PER_BIT cycles, starting the cycle after acceptance:
    - start bit (TXD=0);
    - DATA_BITS data bits, LSB first;
    - one stop bit (TXD=1).
  - tx_ready and tx_busy return to idle values on the cycle after the stop bit ends.
  - Frame length: (DATA_BITS+2)×CLKS_PER_BIT cycles.
  - tx_valid while busy is ignored. No queuing.
- Loopback:
  - loopback=1 forces rx_valid=0 and tx_ready=0 at the ports. The core's rx_ready and tx_valid are ignored.
  - Internally, whenever the FIFO is non-empty and TX is IDLE, the head is popped and loaded into TX in the same cycle.
  - Toggling loopback never aborts an in-flight TX or RX frame. It only gates new handshakes, from the cycle it changes.
- All outputs are registered except rx_valid and tx_ready, which are combinational from state and loopback.

Test Plan:
- Bench parameters: CLKS_PER_BIT=8, DATA_BITS=8, FIFO_DEPTH=4.
- Reset, then hold RESET=1 idle for 100 cycles -> TXD=1, rx_valid=0, rx_count=0, tx_ready=1, no pulses.
- Drive frame 0xA5 on RXD, rx_ready=0 -> rx_valid=1 and rx_data=0xA5 one cycle after the stop sample, rx_count=1. Pulse rx_ready -> rx_count=0 next cycle.
- tx_data=0x3C, tx_valid pulse -> TXD sequence 0,0,0,1,1,1,1,0,0,1 with each bit 8 cycles. tx_ready=0 for exactly 80 cycles.
- Send 5 back-to-back frames 0x01..0x05 with rx_ready=0 -> rx_count=4, one rx_overrun pulse on the 5th frame. Pops yield 0x01..0x04 in order.
- Frame with stop bit low, then a 3-cycle low glitch -> one frame_err pulse, no push; the glitch produces no event; rx_count unchanged.
- loopback=1, receive 0x5A, 0xC3 -> TXD re-emits 0x5A then 0xC3; rx_valid stays 0; tx_valid asserted during the test is ignored. Additionally, assert RESET mid TX frame -> TXD=1 the next cycle, FIFO empty.
